// File: rtl/debounce_pkg.sv
// Shared constants, counter-width helpers and the per-channel status record
// for the multi-button debouncer.
package debounce_pkg;

  localparam int DEF_N_CH           = 4;
  localparam int DEF_DIV            = 131072;
  localparam int DEF_STABLE_SAMPLES = 3;
  localparam int DEF_REPEAT_DELAY   = 64;
  localparam int DEF_REPEAT_RATE    = 16;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic rpt;
  } ch_status_t;

  function automatic int prescale_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

  function automatic int stable_w(input int samples);
    return $clog2(samples + 1);
  endfunction

  function automatic int repeat_w(input int delay, input int rate);
    return $clog2(((delay > rate) ? delay : rate) + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, tick-sampled stability counter,
// registered edge pulses and, with MULTI_BTN_DEBOUNCER_AUTO_REPEAT_EN, auto-repeat.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE    = DEF_REPEAT_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn,
  output ch_status_t status
);

  localparam int SW = stable_w(STABLE_SAMPLES);
  localparam logic [SW-1:0] SS_LAST = SW'(STABLE_SAMPLES - 1);

  if (STABLE_SAMPLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("debounce_channel: STABLE_SAMPLES, REPEAT_DELAY and REPEAT_RATE must be >= 1");
  end

  logic [1:0]    sync;
  logic          s;
  logic          level;
  logic [SW-1:0] cnt;
  logic          rise;
  logic          fall;
  logic          rpt;
  logic          accept;

  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], btn};
  end

  assign s = sync[1];

  // A new level is taken on the tick that completes STABLE_SAMPLES differing samples.
  assign accept = tick && (s != level) && (cnt == SS_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (tick) begin
        if (s == level) begin
          cnt <= '0;
        end else if (accept) begin
          level <= s;
          cnt   <= '0;
          rise  <= s;
          fall  <= ~s;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef MULTI_BTN_DEBOUNCER_AUTO_REPEAT_EN
  localparam int RW = repeat_w(REPEAT_DELAY, REPEAT_RATE);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);

  logic [RW-1:0] rcnt;
  logic          rpt_phase;  // 0: waiting out the initial delay, 1: steady repeat rate

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt      <= '0;
      rpt_phase <= 1'b0;
      rpt       <= 1'b0;
    end else begin
      rpt <= 1'b0;
      if (accept) begin
        rcnt      <= '0;
        rpt_phase <= 1'b0;
      end else if (tick && level) begin
        if (rcnt == (rpt_phase ? RR_LAST : RD_LAST)) begin
          rpt       <= 1'b1;
          rcnt      <= '0;
          rpt_phase <= 1'b1;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end
    end
  end
`else
  assign rpt = 1'b0;
`endif

  assign status = '{level: level, rise: rise, fall: fall, rpt: rpt};

endmodule

// File: rtl/multi_btn_debouncer.sv
// N-channel button conditioner: one shared sample-tick prescaler feeding N debounce channels.
// Define MULTI_BTN_DEBOUNCER_AUTO_REPEAT_EN to build the per-channel auto-repeat pulse.
module multi_btn_debouncer
  import debounce_pkg::*;
#(
  parameter int N_CH           = DEF_N_CH,
  parameter int DIV            = DEF_DIV,
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE    = DEF_REPEAT_RATE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_i,
  output logic            tick_o,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic [N_CH-1:0] rpt_o
);

  localparam int PW = prescale_w(DIV);
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

  if (N_CH < 1 || DIV < 2) begin : g_bad_param
    $error("multi_btn_debouncer: N_CH must be >= 1 and DIV >= 2");
  end

  logic [PW-1:0] pcnt;
  ch_status_t    st [N_CH];

  always_ff @(posedge clk) begin
    if (rst)                   pcnt <= '0;
    else if (pcnt == DIV_LAST) pcnt <= '0;
    else                       pcnt <= pcnt + 1'b1;
  end

  // Decoded from the count register, so it is low throughout reset.
  assign tick_o = (pcnt == DIV_LAST);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick_o),
      .btn    (btn_i[i]),
      .status (st[i])
    );

    assign level_o[i] = st[i].level;
    assign rise_o[i]  = st[i].rise;
    assign fall_o[i]  = st[i].fall;
    assign rpt_o[i]   = st[i].rpt;
  end

endmodule
